// File: rtl/mem_responder_if.sv
// Request/response bundle between a pipeline memory port and mem_responder.
// The requester drives the request fields; the responder drives handshake status and response.
interface mem_responder_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory with a one-outstanding request/response handshake.
// A request is latched at acceptance; the array is touched only on the final WAIT edge.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_idx_nxt;
    logic                  r_wr;
    logic                  w_wr_nxt;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     w_wdata_nxt;
    logic                  w_access;
    logic                  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_data;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    // Byte-select bit and high address bits alias onto the same word.
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.req_addr[0], bus.req_addr[ADDR_W-1:DEPTH_LOG2+1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_wr    <= w_wr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_wr_nxt    = r_wr;
        w_wdata_nxt = r_wdata;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_idx_nxt   = bus.req_addr[DEPTH_LOG2:1];
                    w_wr_nxt    = bus.req_wr;
                    w_wdata_nxt = bus.req_wdata;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Array has no reset; a request dropped by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (w_access && r_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_access;
            if (w_access) begin
                r_resp_data <= r_wr ? r_wdata : r_mem[r_idx];
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state == S_WAIT);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
endmodule
